// File: rtl/data_mem_pkg.sv
// Shared definitions for the load/store data memory: parameter defaults,
// controller state encoding and the byte-enable width helper.
package data_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;
  localparam int DEPTH_DEF  = 512;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// Request/response bundle between the load/store stage (master) and the
// data memory controller (slave).
interface data_memory_ctrl_if #(
  parameter int DATA_W = data_mem_pkg::DATA_W_DEF,
  parameter int ADDR_W = data_mem_pkg::ADDR_W_DEF
);

  localparam int BE_W = data_mem_pkg::be_width(DATA_W);

  // A request transfers on a cycle where req_valid and req_ready are both 1.
  // The master holds a request until it transfers; req_valid with req_ready=0
  // is simply not taken. Responses are a one-cycle rsp_valid pulse with no
  // backpressure, in request order.
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              init_busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, init_busy
  );

endinterface

// File: rtl/be_ram.sv
// Word-organised storage with a synchronous byte-enable write port and an
// asynchronous read port. Contents are undefined until written.
module be_ram
  import data_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  localparam int BE_W  = be_width(DATA_W),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: clears every word after reset, then serves
// range-checked byte-enable writes and reads with a fixed response latency.
module data_memory_ctrl
  import data_mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int READ_LAT = 1
) (
  input  logic               clock,
  input  logic               reset,
  data_memory_ctrl_if.slave  bus,
  output state_t             dbg_state
);

  localparam int BE_W  = be_width(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] CLR_LAST  = IDX_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic              clr_we;
  logic              ready;
  logic              busy;
  logic              accept;
  logic              in_range;
  logic [IDX_W-1:0]  req_idx;

  logic              ram_we;
  logic [IDX_W-1:0]  ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [BE_W-1:0]   ram_be;
  logic [DATA_W-1:0] ram_rdata;

  logic              p1_valid, p1_err;
  logic [DATA_W-1:0] p1_rdata;
  logic              out_valid, out_err;
  logic [DATA_W-1:0] out_rdata;

  // State register and clear counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clr_we) clr_cnt <= clr_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: if (clr_cnt == CLR_LAST) state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
    endcase
  end

  // Outputs are forced to their reset values for the whole reset cycle, even
  // if the registers still hold RUN from before the reset edge.
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b1;
    clr_we = 1'b0;
    if (!reset) begin
      case (state)
        ST_INIT: clr_we = 1'b1;
        ST_RUN: begin
          ready = 1'b1;
          busy  = 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = ready;
  assign bus.init_busy = busy;
  assign dbg_state     = state;

  // Full-width compare first; the index is only taken from checked addresses.
  assign in_range = {1'b0, bus.req_addr} < DEPTH_EXT;
  assign req_idx  = in_range ? bus.req_addr[IDX_W-1:0] : '0;
  assign accept   = bus.req_valid & ready;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = req_idx;
    ram_wdata = bus.req_wdata;
    ram_be    = bus.req_be;
    if (clr_we) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
      ram_be    = '1;
    end else if (accept && bus.req_write && in_range) begin
      ram_we = 1'b1;
    end
  end

  be_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .be    (ram_be),
    .raddr (req_idx),
    .rdata (ram_rdata)
  );

  // Read data is captured at acceptance, before any same-edge write lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_valid <= 1'b0;
      p1_err   <= 1'b0;
      p1_rdata <= '0;
    end else begin
      p1_valid <= accept;
      p1_err   <= accept & ~in_range;
      p1_rdata <= (accept && !bus.req_write && in_range) ? ram_rdata : '0;
    end
  end

  generate
    if (READ_LAT == 2) begin : g_lat2
      logic              p2_valid, p2_err;
      logic [DATA_W-1:0] p2_rdata;
      always_ff @(posedge clock) begin
        if (reset) begin
          p2_valid <= 1'b0;
          p2_err   <= 1'b0;
          p2_rdata <= '0;
        end else begin
          p2_valid <= p1_valid;
          p2_err   <= p1_err;
          p2_rdata <= p1_rdata;
        end
      end
      assign out_valid = p2_valid;
      assign out_err   = p2_err;
      assign out_rdata = p2_rdata;
    end else begin : g_lat1
      assign out_valid = p1_valid;
      assign out_err   = p1_err;
      assign out_rdata = p1_rdata;
    end
  endgenerate

  assign bus.rsp_valid = out_valid & ~reset;
  assign bus.rsp_err   = out_valid & out_err & ~reset;
  assign bus.rsp_rdata = (out_valid && !reset) ? out_rdata : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: READ_LAT=1 and READ_LAT=2 instances share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_data_memory_ctrl;
  import data_mem_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 512;
  localparam int BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } rsp_t;

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
  data_memory_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();
  state_t dbg_a, dbg_b;

  data_memory_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(1)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_a),
    .dbg_state (dbg_a)
  );

  data_memory_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .READ_LAT(2)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_b),
    .dbg_state (dbg_b)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DATA_W-1:0] mem_m [DEPTH];
  bit   m_run;
  int   m_cnt;
  rsp_t exp_q_a[$];
  rsp_t exp_q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  rsp_t s_a, s_b;
  logic s_a_ready, s_a_busy, s_b_ready, s_b_busy;
  int   pulses;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic flush_model();
    exp_q_a.delete();
    exp_q_b.delete();
    exp_q_a.push_back('0);
    exp_q_b.push_back('0);
    exp_q_b.push_back('0);
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, sample/check outputs, then advance the
  // model across the coming rising edge.
  task automatic do_cycle(input logic rst, input logic valid, input logic write,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                          input logic [BE_W-1:0] be);
    rsp_t exp_a, exp_b, rec;
    int   idx;
    @(negedge clock);
    reset           = rst;
    bus_a.req_valid = valid;  bus_b.req_valid = valid;
    bus_a.req_write = write;  bus_b.req_write = write;
    bus_a.req_addr  = addr;   bus_b.req_addr  = addr;
    bus_a.req_wdata = wdata;  bus_b.req_wdata = wdata;
    bus_a.req_be    = be;     bus_b.req_be    = be;
    #1;
    s_a       = '{bus_a.rsp_valid, bus_a.rsp_rdata, bus_a.rsp_err};
    s_b       = '{bus_b.rsp_valid, bus_b.rsp_rdata, bus_b.rsp_err};
    s_a_ready = bus_a.req_ready;  s_a_busy = bus_a.init_busy;
    s_b_ready = bus_b.req_ready;  s_b_busy = bus_b.init_busy;
    exp_a = rst ? rsp_t'('0) : exp_q_a[0];
    exp_b = rst ? rsp_t'('0) : exp_q_b[0];
    check("a_rsp_valid", s_a.valid, exp_a.valid);
    check("a_rsp_rdata", s_a.rdata, exp_a.rdata);
    check("a_rsp_err",   s_a.err,   exp_a.err);
    check("a_req_ready", s_a_ready, m_run && !rst);
    check("a_init_busy", s_a_busy,  !m_run || rst);
    check("b_rsp_valid", s_b.valid, exp_b.valid);
    check("b_rsp_rdata", s_b.rdata, exp_b.rdata);
    check("b_rsp_err",   s_b.err,   exp_b.err);
    check("b_req_ready", s_b_ready, m_run && !rst);
    check("b_init_busy", s_b_busy,  !m_run || rst);
    if (!rst) begin
      check("a_state", dbg_a, m_run ? ST_RUN : ST_INIT);
      check("b_state", dbg_b, m_run ? ST_RUN : ST_INIT);
    end

    if (rst) begin
      m_run = 1'b0;
      m_cnt = 0;
      flush_model();
    end else begin
      rec = '0;
      if (!m_run) begin
        mem_m[m_cnt] = '0;
        m_cnt++;
        if (m_cnt == DEPTH) m_run = 1'b1;
      end else if (valid) begin
        rec.valid = 1'b1;
        idx = int'(addr);
        if (idx >= DEPTH) begin
          rec.err = 1'b1;
        end else if (!write) begin
          rec.rdata = mem_m[idx];
        end else begin
          for (int i = 0; i < BE_W; i++)
            if (be[i]) mem_m[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
      exp_q_a.push_back(rec);
      exp_q_b.push_back(rec);
      void'(exp_q_a.pop_front());
      void'(exp_q_b.pop_front());
    end
  endtask

  task automatic idle(input logic rst);
    do_cycle(rst, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic wait_init(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < DEPTH + 50; i++) begin
      idle(1'b0);
      pulses += int'(s_a.valid) + int'(s_b.valid);
      if (!s_a_busy && !s_b_busy) break;
      busy_cycles++;
    end
    check("init_done_ready", {30'd0, s_a_ready, s_b_ready}, 32'd3);
  endtask

  task automatic run_vec(input vec_t v, input int n);
    do_cycle(1'b0, 1'b1, v.write, v.addr, v.wdata, v.be);
    idle(1'b0);
    check($sformatf("vec%0d_a_valid", n), s_a.valid, 1'b1);
    check($sformatf("vec%0d_a_rdata", n), s_a.rdata, v.exp_rdata);
    check($sformatf("vec%0d_a_err",   n), s_a.err,   v.exp_err);
    idle(1'b0);
    check($sformatf("vec%0d_b_valid", n), s_b.valid, 1'b1);
    check($sformatf("vec%0d_b_rdata", n), s_b.rdata, v.exp_rdata);
    check($sformatf("vec%0d_b_err",   n), s_b.err,   v.exp_err);
  endtask

  // ---------------- test sequence ----------------
  vec_t tbl[18];

  initial begin
    int n;
    int r;
    logic [ADDR_W-1:0] ra;

    tbl[0]  = '{1'b0, 16'd0,     16'h0000, 2'b00, 16'h0000, 1'b0}; // cleared by init
    tbl[1]  = '{1'b0, 16'd255,   16'h0000, 2'b11, 16'h0000, 1'b0};
    tbl[2]  = '{1'b0, 16'd511,   16'h0000, 2'b11, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'd3,     16'h0000, 2'b11, 16'h0000, 1'b0}; // INIT writes ignored
    tbl[4]  = '{1'b1, 16'd5,     16'hABCD, 2'b11, 16'h0000, 1'b0};
    tbl[5]  = '{1'b1, 16'd5,     16'h12FF, 2'b01, 16'h0000, 1'b0};
    tbl[6]  = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hABFF, 1'b0};
    tbl[7]  = '{1'b1, 16'd5,     16'h5A5A, 2'b00, 16'h0000, 1'b0}; // be=0 no-op
    tbl[8]  = '{1'b0, 16'd5,     16'h0000, 2'b01, 16'hABFF, 1'b0};
    tbl[9]  = '{1'b1, 16'd6,     16'h3456, 2'b10, 16'h0000, 1'b0};
    tbl[10] = '{1'b0, 16'd6,     16'h0000, 2'b11, 16'h3400, 1'b0};
    tbl[11] = '{1'b1, 16'd0,     16'h0F0F, 2'b11, 16'h0000, 1'b0};
    tbl[12] = '{1'b1, 16'd512,   16'hBEEF, 2'b11, 16'h0000, 1'b1};
    tbl[13] = '{1'b0, 16'd512,   16'h0000, 2'b11, 16'h0000, 1'b1};
    tbl[14] = '{1'b0, 16'd0,     16'h0000, 2'b11, 16'h0F0F, 1'b0}; // no aliasing
    tbl[15] = '{1'b1, 16'hFFFF,  16'h1234, 2'b11, 16'h0000, 1'b1};
    tbl[16] = '{1'b0, 16'hFFFF,  16'h0000, 2'b11, 16'h0000, 1'b1};
    tbl[17] = '{1'b1, 16'd511,   16'hC3C3, 2'b11, 16'h0000, 1'b0};

    bus_a.req_valid = 1'b0; bus_b.req_valid = 1'b0;
    bus_a.req_write = 1'b0; bus_b.req_write = 1'b0;
    bus_a.req_addr  = '0;   bus_b.req_addr  = '0;
    bus_a.req_wdata = '0;   bus_b.req_wdata = '0;
    bus_a.req_be    = '0;   bus_b.req_be    = '0;
    m_run  = 1'b0;
    m_cnt  = 0;
    pulses = 0;
    flush_model();

    // Reset release: init_busy for exactly DEPTH cycles
    repeat (3) idle(1'b1);
    wait_init(n);
    check("init_len", n, DEPTH);

    // Preload nonzero words, then reset again and pulse requests during INIT
    do_cycle(1'b0, 1'b1, 1'b1, 16'd0,   16'h1357, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b1, 16'd255, 16'h2468, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b1, 16'd511, 16'h9ABC, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b1, 16'd3,   16'h7E7E, 2'b11);
    repeat (2) idle(1'b0);
    repeat (2) idle(1'b1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b0, 1'b1, i[0], 16'd3, 16'hFFFF, 2'b11);
      pulses += int'(s_a.valid) + int'(s_b.valid);
    end
    wait_init(n);
    check("init_len_after_pulses", n, DEPTH - 20);
    check("init_no_rsp", pulses, 0);

    for (int i = 0; i < 18; i++) run_vec(tbl[i], i);

    // Back-to-back write then read at READ_LAT=2
    do_cycle(1'b0, 1'b1, 1'b1, 16'd10, 16'h1111, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b0, 16'd10, 16'h0000, 2'b00);
    idle(1'b0);
    check("b2b_b_wr_valid", s_b.valid, 1'b1);
    check("b2b_b_wr_rdata", s_b.rdata, 16'h0000);
    check("b2b_b_wr_err",   s_b.err,   1'b0);
    check("b2b_a_rd_rdata", s_a.rdata, 16'h1111);
    idle(1'b0);
    check("b2b_b_rd_valid", s_b.valid, 1'b1);
    check("b2b_b_rd_rdata", s_b.rdata, 16'h1111);

    // Write after read must not change the read's response
    do_cycle(1'b0, 1'b1, 1'b1, 16'd20, 16'h5555, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b0, 16'd20, 16'h0000, 2'b11);
    do_cycle(1'b0, 1'b1, 1'b1, 16'd20, 16'h7777, 2'b11);
    idle(1'b0);
    check("raw_b_rd_rdata", s_b.rdata, 16'h5555);
    idle(1'b0);
    run_vec('{1'b0, 16'd20, 16'h0000, 2'b11, 16'h7777, 1'b0}, 100);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      ra = 16'($urandom_range(DEPTH, 65535));
      else if (r == 1) ra = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'(DEPTH - 1);
      else if (r < 6)  ra = 16'($urandom_range(0, 15));
      else             ra = 16'($urandom_range(0, DEPTH - 1));
      do_cycle(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), ra,
               16'($urandom), 2'($urandom_range(0, 3)));
    end
    repeat (3) idle(1'b0);

    // Reset one cycle after accepting a read
    do_cycle(1'b0, 1'b1, 1'b0, 16'd5, 16'h0000, 2'b11);
    idle(1'b1);
    check("rst_a_no_valid", s_a.valid, 1'b0);
    check("rst_b_no_valid", s_b.valid, 1'b0);
    pulses = 0;
    idle(1'b0);
    check("rst_busy_after", s_a_busy, 1'b1);
    pulses += int'(s_a.valid) + int'(s_b.valid);
    wait_init(n);
    check("rst_init_len", n, DEPTH - 1);
    check("rst_no_rsp", pulses, 0);
    run_vec('{1'b0, 16'd5, 16'h0000, 2'b11, 16'h0000, 1'b0}, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised successor data memory for the RISC core's load/store path: configurable width and depth, byte-enable writes, and a valid/ready request port with fixed-latency responses.
- Adds a hardware clear sequencer that zeroes every word after reset, and range checking with an error flag.
- Responses are always driven, never high-impedance.
- Sits between the load/store stage and storage; the core stalls on req_ready.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 16, word-address width.
- DEPTH, 512, number of words; 2 <= DEPTH <= 2^ADDR_W.
- READ_LAT, 1, request-to-response latency in cycles; legal values 1 or 2.
- BE_W, DATA_W/8, derived byte-enable width; not overridable.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte enables; bit i covers bits [8i+7:8i].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes, errors and idle cycles.
- rsp_err  out  1  address out of range; qualified by rsp_valid.
- init_busy  out  1  clear sequence in progress.

Behaviour:
- Reset values while reset=1: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_busy=1, state=INIT, clear counter=0, response pipeline flushed. No memory word is written while reset=1.
- FSM has two states, INIT and RUN.
  - INIT: the first cycle with reset=0 is cycle 0. Word k is zeroed at cycle k, for k = 0..DEPTH-1. This covers all DEPTH words, including the top word.
  - At cycle DEPTH the FSM enters RUN: init_busy=0 and req_ready=1 on that cycle.
  - RUN: req_ready=1 constantly; INIT is re-entered only on reset.
- Accept: a request is accepted when req_valid & req_ready. req_valid while req_ready=0 is ignored and not queued.
- Write:
  - For each i with req_be[i]=1, the byte is updated at the accepting edge.
  - Bytes with req_be[i]=0 are unchanged. req_be=0 is a legal no-op.
- Read: returns the full word; req_be is ignored.
- Response:
  - Every accepted request, read or write, produces exactly one rsp_valid pulse READ_LAT cycles after acceptance.
  - Requests may be accepted on every cycle; responses emerge in order, one per cycle.
  - There is no response backpressure.
- Range check:
  - req_addr >= DEPTH means the write is dropped and memory is unchanged.
  - The response carries rsp_err=1 and rsp_rdata=0 for both reads and writes.
- Read-after-write, same address, back-to-back: the read accepted in cycle N+1 returns the data written in cycle N.
- READ_LAT=2: an extra output register stage sits after the array read. Data is sampled at acceptance, so a write accepted the cycle after a read does not alter that read's response.
- Idle outputs: when rsp_valid=0, rsp_rdata=0 and rsp_err=0.
- Reset mid-operation:
  - In-flight responses are discarded, so no rsp_valid pulse follows the reset edge.
  - The clear sequence restarts from word 0.
  - A write accepted in the same cycle as reset=1 is not possible, because req_ready=0 during reset.
- Width rules:
  - Range compare uses the full ADDR_W.
  - Array index uses the low clog2(DEPTH) bits, and only after the range check passes.

Decomposition:
- Package data_mem_pkg holds:
  - Parameter defaults DATA_W_DEF=16, ADDR_W_DEF=16, DEPTH_DEF=512.
  - State encoding ST_INIT=1'b0, ST_RUN=1'b1.
  - The function be_width(DATA_W).
- Sub-module be_ram: synchronous byte-enable write port plus asynchronous read port, parametrised DATA_W and DEPTH, with no reset.
- data_memory_ctrl owns:
  - The FSM and clear counter.
  - Range check.
  - The muxing of clear writes vs. request writes; during INIT the clear write drives all byte enables to 1 with data 0.
  - The latency pipeline.

Test Plan:
- Reset release with DEPTH=512: init_busy high for exactly 512 cycles and req_ready=1 at cycle 512. A read of addresses 0, 255 and 511, after pre-loading nonzero values before a second reset, returns 0x0000 each.
- Byte-enable merge: write 0xABCD to address 5 with be=2'b11, then write 0x12FF with be=2'b01, then read address 5. The read returns 0xABFF with rsp_valid exactly READ_LAT cycles after each accept.
- Back-to-back pipelining at READ_LAT=2: write 0x1111 to address 10 at cycle N, then read address 10 at N+1. The response at N+3 is 0x1111, preceded at N+2 by the write response with rdata 0 and err 0.
- Out of range: write 0xBEEF to address 512, then read address 512. Both responses have rsp_err=1 and rdata 0. A later read of address 0 returns its prior value unchanged, with no aliasing.
- Stall and reset mid-flight:
  - Pulse req_valid during INIT: no response is ever produced.
  - Assert reset one cycle after accepting a read: no rsp_valid follows, and init_busy=1 on the next cycle.
